// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the device over open-drain ps2c/ps2d.
// Latency: ps2c_oe and tx_idle change in the cycle after an accepted wr_ps2; all outputs are registered.
// Backpressure: wr_ps2 is honoured only while tx_idle=1; requests at any other time are dropped.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   wr_ps2, din         one-cycle send request and the command byte it carries
//   ps2c_in, ps2d_in    raw (asynchronous) pad levels of the shared lines
//   ps2c_oe, ps2d_oe    1 = pull the line low (pads/tri-states live outside)
//   tx_idle             1 while no transfer is in progress
//   tx_done_tick        one-cycle pulse when a transfer ends (ok, nack or timeout)
//   tx_ack_err          device did not ACK the last frame; held until next accepted request
//   tx_timeout          last frame aborted by the watchdog; held until next accepted request
//
// Build option: define PS2_TX_TIMEOUT_EN to add a watchdog (TIMEOUT_CYCLES between
// device clock edges). Without it tx_timeout is tied low and only reset recovers a
// transfer whose device stops clocking.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int FILTER_LEN     = 8
`ifdef PS2_TX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_ack_err,
  output logic       tx_timeout
);

  localparam int CNT_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RTS,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_REL
  } state_t;

  // ------------------------------------------------------------------
  // Input synchronisers and ps2c glitch filter
  // ------------------------------------------------------------------
  logic [1:0]            c_sync_reg, d_sync_reg;
  logic                  c_s, d_s;
  logic [FILTER_LEN-1:0] filt_reg, filt_next;
  logic                  f_c_reg, f_c_next;
  logic                  fall;

  assign c_s = c_sync_reg[1];
  assign d_s = d_sync_reg[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync_reg <= 2'b11;
      d_sync_reg <= 2'b11;
      filt_reg   <= '1;
      f_c_reg    <= 1'b1;
    end else begin
      c_sync_reg <= {c_sync_reg[0], ps2c_in};
      d_sync_reg <= {d_sync_reg[0], ps2d_in};
      filt_reg   <= filt_next;
      f_c_reg    <= f_c_next;
    end
  end

  // Filtered level only moves once the whole window agrees; otherwise it holds.
  always_comb begin
    filt_next    = filt_reg << 1;
    filt_next[0] = c_s;
    if (&filt_reg)
      f_c_next = 1'b1;
    else if (~|filt_reg)
      f_c_next = 1'b0;
    else
      f_c_next = f_c_reg;
  end

  assign fall = f_c_reg & ~f_c_next;

  // ------------------------------------------------------------------
  // Transfer FSM
  // ------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [8:0]       b_reg, b_next;
  logic [3:0]       n_reg, n_next;
  logic             ack_reg, ack_next;
  logic             done_next;
  logic             ack_err_reg, ack_err_next;
  logic             c_oe_reg, c_oe_next;
  logic             d_oe_reg, d_oe_next;
  logic             idle_reg, idle_next;
  logic             done_reg;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wdog_reg, wdog_next;
  logic            timeout_reg, timeout_next;
  logic            wdog_active;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      b_reg       <= '0;
      n_reg       <= '0;
      ack_reg     <= 1'b0;
      ack_err_reg <= 1'b0;
      done_reg    <= 1'b0;
      c_oe_reg    <= 1'b0;
      d_oe_reg    <= 1'b0;
      idle_reg    <= 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
      wdog_reg    <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      b_reg       <= b_next;
      n_reg       <= n_next;
      ack_reg     <= ack_next;
      ack_err_reg <= ack_err_next;
      done_reg    <= done_next;
      c_oe_reg    <= c_oe_next;
      d_oe_reg    <= d_oe_next;
      idle_reg    <= idle_next;
`ifdef PS2_TX_TIMEOUT_EN
      wdog_reg    <= wdog_next;
      timeout_reg <= timeout_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    b_next       = b_reg;
    n_next       = n_reg;
    ack_next     = ack_reg;
    ack_err_next = ack_err_reg;
    done_next    = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    timeout_next = timeout_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        if (wr_ps2) begin
          b_next       = {~^din, din};
          cnt_next     = '0;
          ack_err_next = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
          timeout_next = 1'b0;
`endif
          state_next   = S_RTS;
        end
      end
      S_RTS: begin
        if (cnt_reg == CNT_MAX)
          state_next = S_START;
        else
          cnt_next = cnt_reg + 1'b1;
      end
      S_START: begin
        if (fall) begin
          n_next     = 4'd8;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        // b[0] is the bit on the wire; edges 2..9 advance it, edge 10 ends the payload.
        if (fall) begin
          if (n_reg == 4'd0) begin
            state_next = S_STOP;
          end else begin
            b_next = {1'b0, b_reg[8:1]};
            n_next = n_reg - 4'd1;
          end
        end
      end
      S_STOP: begin
        if (fall) begin
          ack_next   = d_s;
          state_next = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (c_s && d_s) begin
          state_next   = S_IDLE;
          done_next    = 1'b1;
          ack_err_next = ack_reg;
        end
      end
      default: state_next = S_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog spans every state that waits on the device; each clock edge restarts it.
    wdog_active = (state_reg == S_START) || (state_reg == S_DATA) ||
                  (state_reg == S_STOP)  || (state_reg == S_WAIT_REL);
    wdog_next   = (wdog_active && !fall) ? wdog_reg + 1'b1 : '0;
    if (wdog_active && !fall && (wdog_reg == WD_MAX)) begin
      state_next   = S_IDLE;
      done_next    = 1'b1;
      timeout_next = 1'b1;
      wdog_next    = '0;
    end
`endif
  end

  // Line enables are decoded from the next state so they leave a flop glitch-free
  // and track the state register cycle for cycle.
  always_comb begin
    c_oe_next = (state_next == S_RTS);
    d_oe_next = (state_next == S_START) || ((state_next == S_DATA) && !b_next[0]);
    idle_next = (state_next == S_IDLE);
  end

  assign ps2c_oe      = c_oe_reg;
  assign ps2d_oe      = d_oe_reg;
  assign tx_idle      = idle_reg;
  assign tx_done_tick = done_reg;
  assign tx_ack_err   = ack_err_reg;
`ifdef PS2_TX_TIMEOUT_EN
  assign tx_timeout   = timeout_reg;
`else
  assign tx_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a keyboard model answers host requests on wired-AND lines,
// recording each frame bit on the rising device clock and comparing against an
// 11-bit frame computed from the byte's value.
module tb_ps2_host_tx;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_ack_err, tx_timeout;

  logic bfm_c_low = 1'b0;
  logic bfm_d_low = 1'b0;
  int   bfm_edge  = 0;

  // Open-drain lines with pull-ups: low if either side pulls.
  assign ps2c_in = ~(ps2c_oe | bfm_c_low);
  assign ps2d_in = ~(ps2d_oe | bfm_d_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(100),
    .FILTER_LEN(8)
`ifdef PS2_TX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(5000)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_ps2(wr_ps2),
    .din(din),
    .ps2c_in(ps2c_in),
    .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe),
    .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_ack_err(tx_ack_err),
    .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;

  always @(negedge clk) begin
    if (tx_done_tick) done_cnt++;
    if (ps2c_oe && ps2d_oe) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1 (bit 0 goes first).
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2) == 0;
    return {1'b1, par, d, 1'b0};
  endfunction

  // Keyboard model: waits out the host's inhibit, then issues n_edges clocks,
  // sampling ps2d on each rising edge; optionally ACKs during clock 11.
  task automatic bfm(input int n_edges, input bit do_ack,
                     output logic [10:0] fr, output int inh);
    int t;
    fr = '0;
    inh = 0;
    t = 0;
    while (!ps2c_oe && t < 1000) begin @(negedge clk); t++; end
    check("bfm_rts_seen", ps2c_oe, 1'b1);
    while (ps2c_oe && inh < 1000) begin inh++; @(negedge clk); end
    repeat (HALF) @(negedge clk);
    fr[0] = ps2d_in;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11 && do_ack) bfm_d_low = 1'b1;
      bfm_c_low = 1'b1;
      bfm_edge  = k;
      repeat (HALF) @(negedge clk);
      bfm_c_low = 1'b0;
      if (k <= 10) fr[k] = ps2d_in;
      if (k == 11) bfm_d_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d, input int n_edges, input bit do_ack,
                      output logic [10:0] fr, output int inh);
    @(negedge clk);
    din = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    check("lat_ps2c_oe", ps2c_oe, 1'b1);
    check("lat_tx_idle", tx_idle, 1'b0);
    check("accept_clears_ack_err", tx_ack_err, 1'b0);
    check("accept_clears_timeout", tx_timeout, 1'b0);
    bfm(n_edges, do_ack, fr, inh);
  endtask

  task automatic finish_frame(input string tag, input int done_before, input bit exp_err);
    int t;
    t = 0;
    while (!tx_idle && t < 500) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    check({tag, "_idle"}, tx_idle, 1'b1);
    check({tag, "_done_once"}, done_cnt - done_before, 1);
    check({tag, "_ack_err"}, tx_ack_err, exp_err);
    check({tag, "_oe_released"}, {ps2c_oe, ps2d_oe}, 2'b00);
  endtask

  initial begin
    logic [10:0] fr;
    int          inh;
    int          d0;
    int          t;
    logic [7:0]  rd;
    bit          rack;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_ps2c_oe", ps2c_oe, 1'b0);
    check("rst_ps2d_oe", ps2d_oe, 1'b0);
    check("rst_tx_idle", tx_idle, 1'b1);
    check("rst_done", tx_done_tick, 1'b0);
    check("rst_ack_err", tx_ack_err, 1'b0);
    check("rst_timeout", tx_timeout, 1'b0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // 1: 0xED with ACK
    d0 = done_cnt;
    send(8'hED, 11, 1'b1, fr, inh);
    check("t1_inhibit_len", inh, 100);
    check("t1_frame", fr, exp_frame(8'hED));
    finish_frame("t1", d0, 1'b0);

    // 2: 0x04 with ACK
    d0 = done_cnt;
    send(8'h04, 11, 1'b1, fr, inh);
    check("t2_frame", fr, exp_frame(8'h04));
    finish_frame("t2", d0, 1'b0);

    // 3: 0xFF, device never ACKs; error must persist while idle
    d0 = done_cnt;
    send(8'hFF, 11, 1'b0, fr, inh);
    check("t3_frame", fr, exp_frame(8'hFF));
    finish_frame("t3", d0, 1'b1);
    repeat (200) @(negedge clk);
    check("t3_ack_err_held", tx_ack_err, 1'b1);

    // 4: stray wr_ps2 mid-data must not disturb the frame
    d0 = done_cnt;
    bfm_edge = 0;
    fork
      send(8'h3C, 11, 1'b1, fr, inh);
      begin
        t = 0;
        while (bfm_edge != 5 && t < 5000) begin @(negedge clk); t++; end
        repeat (10) @(negedge clk);
        din = 8'h00;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
      end
    join
    check("t4_frame", fr, exp_frame(8'h3C));
    finish_frame("t4", d0, 1'b0);

    // 5: reset at edge 6 aborts cleanly, then a fresh send works
    d0 = done_cnt;
    send(8'hED, 6, 1'b0, fr, inh);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_oe", {ps2c_oe, ps2d_oe}, 2'b00);
    check("t5_rst_idle", tx_idle, 1'b1);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    send(8'hED, 11, 1'b1, fr, inh);
    check("t5_frame", fr, exp_frame(8'hED));
    finish_frame("t5", d0, 1'b0);

    // Random bytes and random ACK behaviour
    for (int i = 0; i < 4; i++) begin
      rd   = 8'($urandom);
      rack = 1'($urandom_range(0, 1));
      d0 = done_cnt;
      send(rd, 11, rack, fr, inh);
      check("rnd_frame", fr, exp_frame(rd));
      finish_frame("rnd", d0, !rack);
    end

    // 6: device stops after edge 3
    d0 = done_cnt;
    send(8'hA5, 3, 1'b0, fr, inh);
`ifdef PS2_TX_TIMEOUT_EN
    t = 0;
    while (done_cnt == d0 && t < 6000) begin @(negedge clk); t++; end
    @(negedge clk);
    check("t6_done_once", done_cnt - d0, 1);
    check("t6_timeout", tx_timeout, 1'b1);
    check("t6_oe", {ps2c_oe, ps2d_oe}, 2'b00);
    check("t6_idle", tx_idle, 1'b1);
    check("t6_window", (t >= 4850 && t <= 5050), 1'b1);
`else
    repeat (6000) @(negedge clk);
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_timeout_tied", tx_timeout, 1'b0);
    check("t6_still_busy", tx_idle, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_rst_recovers", tx_idle, 1'b1);
`endif

    check("oe_never_both", overlap_cnt, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
